// File: rtl/control_sequencer.sv
// control_sequencer: registered, handshaked opcode decoder that replays vector opcodes as lane beats.
// Optional CTRL_PERF_CNT_EN adds saturating instruction/beat/illegal counters.
module control_sequencer #(
  parameter int VEC_LANES      = 8,
  parameter int LANES_PER_BEAT = 2,
  parameter int LIDX_W         = (VEC_LANES > 1) ? $clog2(VEC_LANES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4:0]        opcode_i,
  input  logic [2:0]        alu_fn_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [17:0]       ctrl_o,
  output logic [LIDX_W-1:0] lane_base_o,
  output logic              beat_last_o,
  output logic              illegal_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       instr_cnt_o,
  output logic [31:0]       beat_cnt_o,
  output logic [15:0]       illegal_cnt_o
`endif
);
  typedef enum logic {IDLE, VSEQ} state_t;
  localparam bit MULTI = VEC_LANES > LANES_PER_BEAT;
  localparam logic [LIDX_W-1:0] STEP = LIDX_W'(LANES_PER_BEAT);
  localparam logic [LIDX_W-1:0] LAST_BASE = LIDX_W'(VEC_LANES - LANES_PER_BEAT);
  state_t state_q, state_d;
  logic out_valid_q, out_valid_d, last_q, last_d, ill_q, ill_d;
  logic [17:0] ctrl_q, ctrl_d, dec_ctrl;
  logic [LIDX_W-1:0] lane_q, lane_d, lane_nx;
  logic dec_ill, dec_vec, accept, fire;
  always_comb begin
    dec_ctrl = '0;
    dec_ill = 1'b0;
    case (opcode_i)
      5'b00000: dec_ctrl = {6'b001010, alu_fn_i, 9'b000000000};
      5'b01000: dec_ctrl = 18'b001010000010000000;
      5'b01001: dec_ctrl = 18'b001010001010000000;
      5'b00010: dec_ctrl = 18'b001000000101000000;
      5'b00011: dec_ctrl = 18'b001000000101000100;
      5'b00100: dec_ctrl = 18'b000100000100001000;
      5'b00101: dec_ctrl = 18'b000100000100001010;
      5'b10000: dec_ctrl = 18'b010000000000000000;
      5'b00110: dec_ctrl = 18'b100000000000000000;
      5'b10001: dec_ctrl = 18'b000000000000000000;
      5'b01010: dec_ctrl = 18'b000000001000010000;
      5'b01011: dec_ctrl = 18'b000000001000100000;
      5'b11000: dec_ctrl = {6'b000000, alu_fn_i, 9'b000000011};
      5'b11110: dec_ctrl = 18'b000001101000000011;
      5'b11010, 5'b11011: dec_ctrl = 18'b000000000000000011;
      5'b11100, 5'b11101: dec_ctrl = 18'b000100000000000000;
      default: dec_ill = 1'b1;
    endcase
  end
  // undecoded opcodes in the vector space still issue as a single scalar NOP beat
  assign dec_vec = (&opcode_i[4:3]) && !dec_ill;
  assign in_ready_o = (state_q == IDLE) && (!out_valid_q || out_ready_i);
  assign accept = in_valid_i && in_ready_o;
  assign fire = out_valid_q && out_ready_i;
  assign lane_nx = lane_q + STEP;
  always_comb begin
    state_d = state_q;
    out_valid_d = out_valid_q;
    ctrl_d = ctrl_q;
    lane_d = lane_q;
    last_d = last_q;
    ill_d = ill_q;
    if (state_q == IDLE) begin
      if (accept) begin
        ctrl_d = dec_ctrl;
        ill_d = dec_ill;
        lane_d = '0;
        out_valid_d = 1'b1;
        last_d = !(dec_vec && MULTI);
        state_d = (dec_vec && MULTI) ? VSEQ : IDLE;
      end else if (fire) begin
        out_valid_d = 1'b0;
      end
    end else if (fire) begin
      out_valid_d = !last_q;
      lane_d = last_q ? '0 : lane_nx;
      last_d = !last_q && (lane_nx == LAST_BASE);
      state_d = last_q ? IDLE : VSEQ;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      ctrl_q <= '0;
      lane_q <= '0;
      last_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q <= ctrl_d;
      lane_q <= lane_d;
      last_q <= last_d;
      ill_q <= ill_d;
    end
  end
  assign out_valid_o = out_valid_q;
  assign ctrl_o = ctrl_q;
  assign lane_base_o = lane_q;
  assign beat_last_o = last_q;
  assign illegal_o = ill_q;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt_q, beat_cnt_q;
  logic [15:0] illegal_cnt_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_cnt_q <= '0;
      beat_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_q + 32'(accept && !(&instr_cnt_q));
      beat_cnt_q <= beat_cnt_q + 32'(fire && !(&beat_cnt_q));
      illegal_cnt_q <= illegal_cnt_q + 16'(accept && dec_ill && !(&illegal_cnt_q));
    end
  end
  assign instr_cnt_o = instr_cnt_q;
  assign beat_cnt_o = beat_cnt_q;
  assign illegal_cnt_o = illegal_cnt_q;
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-step bench with immediate assertions for control_sequencer.
module tb_control_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0] opcode = '0;
  logic [2:0] alu_fn = '0;
  logic in_ready, out_valid, beat_last, illegal;
  logic [17:0] ctrl;
  logic [2:0] lane_base;
  int n_cmp = 0, n_err = 0;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt, beat_cnt;
  logic [15:0] illegal_cnt;
`endif
  control_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opcode_i(opcode), .alu_fn_i(alu_fn), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ctrl_o(ctrl), .lane_base_o(lane_base), .beat_last_o(beat_last), .illegal_o(illegal)
`ifdef CTRL_PERF_CNT_EN
    , .instr_cnt_o(instr_cnt), .beat_cnt_o(beat_cnt), .illegal_cnt_o(illegal_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  localparam logic [17:0] ADDI = 18'b001010000010000000;
  localparam logic [17:0] LDW = 18'b001000000101000000;
  localparam logic [17:0] STW = 18'b000100000100001000;
  logic [4:0] sc_op [9] = '{5'b00000, 5'b01001, 5'b00011, 5'b00101, 5'b10000,
                            5'b00110, 5'b10001, 5'b01010, 5'b01011};
  logic [17:0] sc_ctrl [9] = '{{6'b001010, 3'b110, 9'b0}, 18'b001010001010000000,
                              18'b001000000101000100, 18'b000100000100001010,
                              18'b010000000000000000, 18'b100000000000000000,
                              18'b0, 18'b000000001000010000, 18'b000000001000100000};
  initial begin
    cyc(); cyc();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ctrl", 32'(ctrl), 0);
    chk("rst_lane", 32'(lane_base), 0);
    chk("rst_last", 32'(beat_last), 0);
    chk("rst_illegal", 32'(illegal), 0);
    rst_n = 1'b1;
    cyc();
    chk("rst_in_ready", 32'(in_ready), 1);
    // ADDI, single beat
    in_valid = 1'b1; opcode = 5'b01000; alu_fn = 3'b000;
    cyc();
    in_valid = 1'b0;
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_ctrl", 32'(ctrl), 32'(ADDI));
    chk("addi_last", 32'(beat_last), 1);
    chk("addi_lane", 32'(lane_base), 0);
    cyc();
    chk("addi_drain", 32'(out_valid), 0);
    // vector ALU, four beats
    in_valid = 1'b1; opcode = 5'b11000; alu_fn = 3'b010;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("vec_valid%0d", k), 32'(out_valid), 1);
      chk($sformatf("vec_lane%0d", k), 32'(lane_base), 32'(2 * k));
      chk($sformatf("vec_last%0d", k), 32'(beat_last), 32'(k == 3));
      chk($sformatf("vec_ctrl%0d", k), 32'(ctrl), 32'({6'b0, 3'b010, 9'b000000011}));
      chk($sformatf("vec_in_ready%0d", k), 32'(in_ready), 0);
      cyc();
    end
    chk("vec_done_valid", 32'(out_valid), 0);
    chk("vec_done_lane", 32'(lane_base), 0);
    chk("vec_done_in_ready", 32'(in_ready), 1);
    // backpressure during beat 1
    in_valid = 1'b1; opcode = 5'b11000; alu_fn = 3'b101;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("bp_lane1", 32'(lane_base), 2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("bp_hold_lane%0d", k), 32'(lane_base), 2);
      chk($sformatf("bp_hold_ctrl%0d", k), 32'(ctrl), 32'({6'b0, 3'b101, 9'b000000011}));
      chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 1);
      chk($sformatf("bp_hold_last%0d", k), 32'(beat_last), 0);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_lane2", 32'(lane_base), 4);
    cyc();
    chk("bp_lane3", 32'(lane_base), 6);
    chk("bp_last3", 32'(beat_last), 1);
    cyc();
    chk("bp_done", 32'(out_valid), 0);
    // back-to-back LDW, STW
    in_valid = 1'b1; opcode = 5'b00010; alu_fn = 3'b000;
    cyc();
    chk("b2b_ldw_ctrl", 32'(ctrl), 32'(LDW));
    chk("b2b_ldw_in_ready", 32'(in_ready), 1);
    opcode = 5'b00100;
    cyc();
    in_valid = 1'b0;
    chk("b2b_stw_valid", 32'(out_valid), 1);
    chk("b2b_stw_ctrl", 32'(ctrl), 32'(STW));
    cyc();
    chk("b2b_drain", 32'(out_valid), 0);
    // scalar decode table
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; opcode = sc_op[k]; alu_fn = 3'b110;
      cyc();
      in_valid = 1'b0;
      chk($sformatf("dec_ctrl_%b", sc_op[k]), 32'(ctrl), 32'(sc_ctrl[k]));
      chk($sformatf("dec_ill_%b", sc_op[k]), 32'(illegal), 0);
      cyc();
    end
    // reset in the middle of a vector sequence
    in_valid = 1'b1; opcode = 5'b11110; alu_fn = 3'b000;
    cyc();
    in_valid = 1'b0;
    chk("vld_ctrl", 32'(ctrl), 32'(18'b000001101000000011));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ctrl", 32'(ctrl), 0);
    chk("midrst_lane", 32'(lane_base), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("midrst_in_ready", 32'(in_ready), 1);
    // illegal opcode
    in_valid = 1'b1; opcode = 5'b01111;
    cyc();
    in_valid = 1'b0;
    chk("ill_ctrl", 32'(ctrl), 0);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_last", 32'(beat_last), 1);
    chk("ill_valid", 32'(out_valid), 1);
`ifdef CTRL_PERF_CNT_EN
    chk("cnt_illegal", 32'(illegal_cnt), 1);
    chk("cnt_instr", instr_cnt, 1);
    chk("cnt_beat", beat_cnt, 0);
`endif
    cyc();
    chk("ill_drain", 32'(out_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
